// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 host transmitter types and command constants
// Contents: transmitter state enum, frame geometry, keyboard command bytes,
// odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        BITS,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // Bit positions 0..7 data, 8 parity, 9 stop.
    localparam logic [3:0] PS2_STOP_IDX = 4'd9;

    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - PS/2 clock synchronizer, glitch filter and falling-edge strobe
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   raw_in      : raw asynchronous PS/2 clock pin
//   level       : filtered clock level (resets high, the idle bus level)
//   fall        : one-cycle strobe when the filtered level goes 1 -> 0
module ps2_clk_filter #(
    parameter int clock_filter = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(clock_filter + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(clock_filter - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // The counter only runs while the synchronized pin disagrees with the
    // filtered level; any sample back at the old level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], raw_in};
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync[1];
                fall  <= level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Ports:
//   clk, rst_n              : system clock, asynchronous active-low reset
//   tx_byte, tx_trigger     : byte to send (LSB first), one-cycle request
//   tx_busy                 : transfer in progress
//   tx_done, tx_error       : one-cycle completion / failure pulses
//   ps2_clk_in, ps2_dat_in  : raw PS/2 pins
//   ps2_clk_oe, ps2_dat_oe  : 1 pulls the corresponding open-drain line low
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int clock_filter   = 24,
    parameter int inhibit_cycles = 12000,
    parameter int timeout_cycles = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_byte,
    input  logic       tx_trigger,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int IW = (inhibit_cycles > 1) ? $clog2(inhibit_cycles) : 1;
    localparam int TW = $clog2(timeout_cycles + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(inhibit_cycles - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(timeout_cycles - 1);

    logic       clk_level;
    logic       fall;
    logic [1:0] dat_sync_r;
    logic       dat_sync;

    ps2_tx_state_t state_q, state_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [9:0]    frame_q, frame_d;
    logic          dat_oe_q, dat_oe_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          watched;

    ps2_clk_filter #(
        .clock_filter(clock_filter)
    ) u_clk_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_in(ps2_clk_in),
        .level (clk_level),
        .fall  (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_sync_r <= 2'b11;
        end else begin
            dat_sync_r <= {dat_sync_r[0], ps2_dat_in};
        end
    end
    assign dat_sync = dat_sync_r[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_idx_q <= '0;
            frame_q   <= '0;
            dat_oe_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_idx_q <= bit_idx_d;
            frame_q   <= frame_d;
            dat_oe_q  <= dat_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // States in which the device is expected to be clocking.
    assign watched = (state_q == START) || (state_q == BITS) ||
                     (state_q == ACK)   || (state_q == WAIT_IDLE);

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                inh_cnt_d = '0;
                to_cnt_d  = '0;
                bit_idx_d = '0;
                dat_oe_d  = 1'b0;
                if (tx_trigger) begin
                    frame_d = {1'b1, ps2_odd_parity(tx_byte), tx_byte};
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    inh_cnt_d = '0;
                    state_d   = START;
                end else begin
                    inh_cnt_d = inh_cnt_q + IW'(1);
                end
            end
            START: begin
                if (fall) begin
                    dat_oe_d  = ~frame_q[0];
                    bit_idx_d = 4'd1;
                    state_d   = BITS;
                end
            end
            BITS: begin
                if (fall) begin
                    dat_oe_d  = ~frame_q[bit_idx_q];
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == PS2_STOP_IDX) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    if (dat_sync) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_level && dat_sync) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timeout has priority over a same-cycle completion so that done and
        // error can never pulse together.
        if (watched) begin
            if (fall) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_LAST) begin
                to_cnt_d = '0;
                dat_oe_d = 1'b0;
                done_d   = 1'b0;
                error_d  = 1'b1;
                state_d  = IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
    end

    // Line drives decode straight from state so an asynchronous reset
    // releases the bus without waiting for a clock edge.
    assign ps2_clk_oe = (state_q == INHIBIT);
    assign ps2_dat_oe = ((state_q == INHIBIT) && (inh_cnt_q == INH_LAST)) ||
                        (state_q == START) ||
                        ((state_q == BITS) && dat_oe_q);
    assign tx_busy    = (state_q != IDLE);
    assign tx_done    = done_q;
    assign tx_error   = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int CF   = 4;
    localparam int INH  = 50;
    localparam int TO   = 2000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_trigger = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    wire line_clk = dev_clk & ~ps2_clk_oe;
    wire line_dat = dev_dat & ~ps2_dat_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .clock_filter  (CF),
        .inhibit_cycles(INH),
        .timeout_cycles(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_byte   (tx_byte),
        .tx_trigger(tx_trigger),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .ps2_clk_in(line_clk),
        .ps2_dat_in(line_dat),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int drop_bad = 0;
    logic prev_busy = 1'b0;
    logic [9:0] exp_q[$];
    logic [9:0] last_frame;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_error) err_cnt++;
        if (tx_done && tx_error) both_cnt++;
        if (rst_n && prev_busy && !tx_busy && !(tx_done || tx_error)) drop_bad++;
        prev_busy = rst_n ? tx_busy : 1'b0;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] make_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
    endfunction

    // Trigger a transfer and check the inhibit window; returns in the first
    // cycle of START.
    task automatic start_tx(input logic [7:0] b, input string tag);
        int hi = 0;
        int dat_first = 0;
        exp_q.push_back(make_frame(b));
        tx_byte    = b;
        tx_trigger = 1'b1;
        tick();
        tx_trigger = 1'b0;
        tx_byte    = 8'h00;
        check_eq({tag, " busy_after_trigger"}, 32'(tx_busy), 32'd1);
        check_eq({tag, " clk_oe_after_trigger"}, 32'(ps2_clk_oe), 32'd1);
        while (ps2_clk_oe && hi < INH + 20) begin
            hi++;
            if (ps2_dat_oe && dat_first == 0) dat_first = hi;
            tick();
        end
        check_eq({tag, " inhibit_len"}, 32'(hi), 32'(INH));
        check_eq({tag, " dat_oe_lead"}, 32'(dat_first), 32'(INH));
        check_eq({tag, " start_bit"}, 32'(ps2_dat_oe), 32'd1);
    endtask

    // Device model: 11 clock pulses, samples the line on each rising edge,
    // drives ACK low on the 11th pulse when asked. mode 1 injects a trigger
    // during BITS, mode 2 asserts reset during BITS.
    task automatic run_device(input int mode, input bit ack, input string tag);
        logic [9:0] got = '0;
        logic [9:0] exp;
        bit aborted = 1'b0;
        int d0 = done_cnt;
        int e0 = err_cnt;
        int k = 0;
        for (int i = 1; i <= 11; i++) begin
            repeat (HALF) tick();
            dev_clk = 1'b0;
            for (int t = 0; t < HALF; t++) begin
                tick();
                if (mode == 1 && i == 4 && t == 0) begin
                    tx_byte    = 8'h55;
                    tx_trigger = 1'b1;
                end
                if (mode == 1 && i == 4 && t == 1) begin
                    tx_trigger = 1'b0;
                    tx_byte    = 8'h00;
                end
                if (mode == 2 && i == 5 && t == 10) begin
                    check_eq({tag, " pre_reset_dat_oe"}, 32'(ps2_dat_oe), 32'd1);
                    rst_n = 1'b0;
                    #1;
                    check_eq({tag, " async_clk_oe"}, 32'(ps2_clk_oe), 32'd0);
                    check_eq({tag, " async_dat_oe"}, 32'(ps2_dat_oe), 32'd0);
                    check_eq({tag, " async_busy"}, 32'(tx_busy), 32'd0);
                    aborted = 1'b1;
                    break;
                end
            end
            if (aborted) break;
            dev_clk = 1'b1;
            if (i <= 10) got[i-1] = line_dat;
            if (i == 10 && ack) dev_dat = 1'b0;
            if (i == 11) dev_dat = 1'b1;
        end
        check_eq({tag, " sb_size"}, 32'(exp_q.size()), 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
        if (aborted) begin
            dev_clk = 1'b1;
            dev_dat = 1'b1;
            repeat (3) tick();
            rst_n = 1'b1;
            repeat (2) tick();
            return;
        end
        last_frame = got;
        check_eq({tag, " frame"}, 32'(got), 32'(exp));
        while (tx_busy && k < 500) begin
            tick();
            k++;
        end
        tick();
        check_eq({tag, " done_pulses"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
        check_eq({tag, " error_pulses"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
        check_eq({tag, " busy_end"}, 32'(tx_busy), 32'd0);
        check_eq({tag, " clk_oe_end"}, 32'(ps2_clk_oe), 32'd0);
        check_eq({tag, " dat_oe_end"}, 32'(ps2_dat_oe), 32'd0);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       par;
    } par_case_t;

    initial begin
        par_case_t pc[3];
        int k;
        int e0;
        int seen;

        pc[0] = '{8'h01, 1'b0};
        pc[1] = '{8'h00, 1'b1};
        pc[2] = '{8'hFF, 1'b1};

        repeat (5) tick();
        check_eq("reset clk_oe", 32'(ps2_clk_oe), 32'd0);
        check_eq("reset dat_oe", 32'(ps2_dat_oe), 32'd0);
        check_eq("reset busy", 32'(tx_busy), 32'd0);
        check_eq("reset done", 32'(tx_done), 32'd0);
        check_eq("reset error", 32'(tx_error), 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();

        start_tx(PS2_CMD_SET_LEDS, "ed");
        run_device(0, 1'b1, "ed");
        check_eq("ed wire_bits", 32'(last_frame), 32'(10'b11_1110_1101));

        foreach (pc[i]) begin
            start_tx(pc[i].b, "par");
            run_device(0, 1'b1, "par");
            check_eq($sformatf("parity_%02h", pc[i].b), 32'(last_frame[8]), 32'(pc[i].par));
        end

        start_tx(8'hA5, "noack");
        run_device(0, 1'b0, "noack");

        start_tx(PS2_CMD_RESET, "silent");
        e0 = err_cnt;
        k = 0;
        while (!tx_error && k < TO + 50) begin
            tick();
            k++;
        end
        check_eq("silent timeout_cycles", 32'(k), 32'(TO));
        check_eq("silent clk_oe", 32'(ps2_clk_oe), 32'd0);
        check_eq("silent dat_oe", 32'(ps2_dat_oe), 32'd0);
        check_eq("silent busy", 32'(tx_busy), 32'd0);
        tick();
        check_eq("silent error_pulses", 32'(err_cnt - e0), 32'd1);
        void'(exp_q.pop_front());

        start_tx(PS2_CMD_SET_LEDS, "busytrig");
        run_device(1, 1'b1, "busytrig");
        seen = 0;
        repeat (100) begin
            tick();
            if (ps2_clk_oe) seen++;
        end
        check_eq("busytrig no_second_frame", 32'(seen), 32'd0);

        start_tx(PS2_CMD_SET_LEDS, "rst");
        run_device(2, 1'b1, "rst");
        start_tx(PS2_CMD_SET_LEDS, "after_rst");
        run_device(0, 1'b1, "after_rst");

        check_eq("done_error_exclusive", 32'(both_cnt), 32'd0);
        check_eq("busy_drops_with_pulse", 32'(drop_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
